// File: rtl/mcu_intc_if.sv
// CPU-facing register port and interrupt request/acknowledge handshake of the MCU
// interrupt controller. The master side is the CPU and the slave side is the controller.
interface mcu_intc_if #(
  parameter int ID_W  = 4,
  parameter int VEC_W = 16
);
  logic              bus_en;
  logic              bus_rw;
  logic [1:0]        bus_addr;
  logic [15:0]       bus_wdata;
  logic [15:0]       bus_rdata;
  logic              int_req;
  logic              int_ack;
  logic [ID_W-1:0]   int_id;
  logic [VEC_W-1:0]  int_vec;
  logic              in_service;

  modport master (
    output bus_en, bus_rw, bus_addr, bus_wdata, int_ack,
    input  bus_rdata, int_req, int_id, int_vec, in_service
  );

  modport slave (
    input  bus_en, bus_rw, bus_addr, bus_wdata, int_ack,
    output bus_rdata, int_req, int_id, int_vec, in_service
  );
endinterface

// File: rtl/mcu_intc.sv
// Vectored interrupt controller. It handles edge- and level-triggered lines, masks them and
// picks the lowest-index line first. It tracks one in-service interrupt until the CPU writes EOI.
module mcu_intc #(
  parameter int               NIRQ       = 8,
  parameter int               ID_W       = 4,
  parameter int               VEC_W      = 16,
  parameter logic [VEC_W-1:0] VEC_BASE   = VEC_W'(16'h0004),
  parameter int               VEC_STRIDE = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NIRQ-1:0] irq_in,
  mcu_intc_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t            state;
  logic [NIRQ-1:0]   s1, s2, s3;
  logic [NIRQ-1:0]   pending, mask, mode;
  logic [NIRQ-1:0]   pending_next, edge_ev, eligible;
  logic              req_q, in_service_q;
  logic [ID_W-1:0]   id_q, winner;
  logic [VEC_W-1:0]  vec_q;
  logic [15:0]       rdata_q, read_mux, status;
  logic              any_eligible, latched_eligible;
  logic              wr_en, rd_en, ack_fire, eoi;
  logic              unused_wdata;

  assign wr_en        = bus.bus_en & ~bus.bus_rw;
  assign rd_en        = bus.bus_en &  bus.bus_rw;
  assign ack_fire     = (state == REQ) && bus.int_ack;
  assign eoi          = wr_en && (bus.bus_addr == 2'd3);
  assign edge_ev      = s2 & ~s3;
  assign eligible     = pending & mask;
  assign unused_wdata = ^bus.bus_wdata;

  // Lowest index wins, so scan from the top and let lower hits overwrite.
  always_comb begin
    any_eligible     = 1'b0;
    winner           = '0;
    latched_eligible = 1'b0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        any_eligible = 1'b1;
        winner       = ID_W'(i);
      end
      if (id_q == ID_W'(i)) latched_eligible = eligible[i];
    end
  end

  // In edge mode a new edge beats a same-cycle W1C or ack clear. Level lines just track s2.
  always_comb begin
    pending_next = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (mode[i])
        pending_next[i] = edge_ev[i] |
                          (pending[i] & ~((wr_en && bus.bus_addr == 2'd0 && bus.bus_wdata[i]) ||
                                          (ack_fire && id_q == ID_W'(i))));
      else
        pending_next[i] = s2[i];
    end
  end

  always_comb begin
    status             = '0;
    status[15]         = in_service_q;
    status[14]         = req_q;
    status[ID_W-1:0]   = id_q;
    read_mux           = '0;
    case (bus.bus_addr)
      2'd0:    read_mux = 16'(pending);
      2'd1:    read_mux = 16'(mask);
      2'd2:    read_mux = 16'(mode);
      default: read_mux = status;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      s3      <= '0;
      pending <= '0;
      mask    <= '0;
      mode    <= '0;
      rdata_q <= '0;
    end else begin
      s1      <= irq_in;
      s2      <= s1;
      s3      <= s2;
      pending <= pending_next;
      if (wr_en && bus.bus_addr == 2'd1) mask <= bus.bus_wdata[NIRQ-1:0];
      if (wr_en && bus.bus_addr == 2'd2) mode <= bus.bus_wdata[NIRQ-1:0];
      if (rd_en) rdata_q <= read_mux;
    end
  end

  // In REQ the id and vector stay latched until ack or withdrawal, even if a higher-priority line arrives.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      req_q        <= 1'b0;
      in_service_q <= 1'b0;
      id_q         <= '0;
      vec_q        <= VEC_BASE;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            id_q  <= winner;
            vec_q <= VEC_BASE + VEC_W'(winner) * VEC_W'(VEC_STRIDE);
            req_q <= 1'b1;
            state <= REQ;
          end
        end
        REQ: begin
          if (bus.int_ack) begin
            state        <= SERVICE;
            in_service_q <= 1'b1;
            req_q        <= 1'b0;
          end else if (!latched_eligible) begin
            state <= IDLE;
            req_q <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state        <= IDLE;
            in_service_q <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          req_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.bus_rdata  = rdata_q;
  assign bus.int_req    = req_q;
  assign bus.int_id     = id_q;
  assign bus.int_vec    = vec_q;
  assign bus.in_service = in_service_q;

endmodule

// File: tb/tb_mcu_intc.sv
// Directed bench for mcu_intc. It covers reset values, edge and level lines, priority freezing,
// withdrawal, the ack/W1C race and reset during service.
module tb_mcu_intc;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] irq_in = '0;
  logic [15:0] rd;
  int         test_count = 0;
  int         fail_count = 0;

  mcu_intc_if #(.ID_W(4), .VEC_W(16)) bus ();

  mcu_intc #(
    .NIRQ(8), .ID_W(4), .VEC_W(16), .VEC_BASE(16'h0004), .VEC_STRIDE(2)
  ) dut (
    .clock (clock),
    .reset (reset),
    .irq_in(irq_in),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    test_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] pattern, input int cycles);
    irq_in = pattern;
    repeat (cycles) tick();
    irq_in = '0;
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [15:0] data);
    bus.bus_en = 1'b1; bus.bus_rw = 1'b0; bus.bus_addr = addr; bus.bus_wdata = data;
    tick();
    bus.bus_en = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [15:0] data);
    bus.bus_en = 1'b1; bus.bus_rw = 1'b1; bus.bus_addr = addr;
    tick();
    bus.bus_en = 1'b0;
    data = bus.bus_rdata;
  endtask

  task automatic ackOnce();
    bus.int_ack = 1'b1;
    tick();
    bus.int_ack = 1'b0;
  endtask

  task automatic waitReq(input string tag);
    for (int n = 0; n < 20 && !bus.int_req; n++) tick();
    checkOutput(tag, 32'(bus.int_req), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.bus_en = 1'b0; bus.bus_rw = 1'b0; bus.bus_addr = '0; bus.bus_wdata = '0; bus.int_ack = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    // reset state
    for (int a = 0; a < 4; a++) begin
      busRead(2'(a), rd);
      checkOutput($sformatf("reset_reg%0d", a), 32'(rd), 32'h0);
    end
    checkOutput("reset_req", 32'(bus.int_req), 32'd0);
    checkOutput("reset_vec", 32'(bus.int_vec), 32'h0004);
    checkOutput("reset_insvc", 32'(bus.in_service), 32'd0);

    // edge line 3: exact latency, vector, ack, EOI
    busWrite(2'd1, 16'h00FF);
    busWrite(2'd2, 16'h00FF);
    applyStimulus(8'h08, 1);
    repeat (2) tick();
    checkOutput("l3_req_early", 32'(bus.int_req), 32'd0);
    tick();
    checkOutput("l3_req", 32'(bus.int_req), 32'd1);
    checkOutput("l3_id", 32'(bus.int_id), 32'd3);
    checkOutput("l3_vec", 32'(bus.int_vec), 32'h000A);
    ackOnce();
    checkOutput("l3_insvc", 32'(bus.in_service), 32'd1);
    checkOutput("l3_req_off", 32'(bus.int_req), 32'd0);
    busRead(2'd0, rd);
    checkOutput("l3_pend_clr", 32'(rd), 32'h0);
    busRead(2'd3, rd);
    checkOutput("l3_status", 32'(rd), 32'h8003);
    busWrite(2'd3, 16'h0000);
    repeat (2) tick();
    checkOutput("l3_eoi_insvc", 32'(bus.in_service), 32'd0);
    checkOutput("l3_eoi_noreq", 32'(bus.int_req), 32'd0);

    // line 5 in REQ stays latched when line 1 arrives
    applyStimulus(8'h20, 1);
    waitReq("l5_req");
    applyStimulus(8'h02, 1);
    repeat (4) tick();
    checkOutput("l5_id_frozen", 32'(bus.int_id), 32'd5);
    checkOutput("l5_vec", 32'(bus.int_vec), 32'h000E);
    ackOnce();
    busWrite(2'd3, 16'h0000);
    tick();
    checkOutput("l1_rereq", 32'(bus.int_req), 32'd1);
    checkOutput("l1_id", 32'(bus.int_id), 32'd1);
    checkOutput("l1_vec", 32'(bus.int_vec), 32'h0006);
    ackOnce();
    busWrite(2'd3, 16'h0000);
    repeat (2) tick();
    checkOutput("l1_done_noreq", 32'(bus.int_req), 32'd0);

    // level line 2: re-request after EOI, W1C ignored
    busWrite(2'd2, 16'h00FB);
    irq_in = 8'h04;
    waitReq("lv2_req");
    checkOutput("lv2_id", 32'(bus.int_id), 32'd2);
    ackOnce();
    checkOutput("lv2_insvc", 32'(bus.in_service), 32'd1);
    busWrite(2'd3, 16'h0000);
    tick();
    checkOutput("lv2_rereq", 32'(bus.int_req), 32'd1);
    busRead(2'd0, rd);
    checkOutput("lv2_pend", 32'(rd), 32'h0004);
    busWrite(2'd0, 16'h0004);
    busRead(2'd0, rd);
    checkOutput("lv2_w1c_ignored", 32'(rd), 32'h0004);
    ackOnce();
    irq_in = 8'h00;
    repeat (4) tick();
    busWrite(2'd3, 16'h0000);
    repeat (2) tick();
    checkOutput("lv2_drop_noreq", 32'(bus.int_req), 32'd0);
    busWrite(2'd2, 16'h00FF);

    // edge line 4: withdrawal on mask-off, then ack racing W1C
    applyStimulus(8'h10, 1);
    waitReq("l4_req");
    checkOutput("l4_id", 32'(bus.int_id), 32'd4);
    busWrite(2'd1, 16'h00EF);
    tick();
    checkOutput("l4_withdrawn", 32'(bus.int_req), 32'd0);
    repeat (2) tick();
    checkOutput("l4_stays_idle", 32'(bus.int_req), 32'd0);
    checkOutput("l4_no_insvc", 32'(bus.in_service), 32'd0);
    busRead(2'd0, rd);
    checkOutput("l4_pend_kept", 32'(rd), 32'h0010);
    busWrite(2'd1, 16'h00FF);
    waitReq("l4_rereq");
    bus.bus_en = 1'b1; bus.bus_rw = 1'b0; bus.bus_addr = 2'd0; bus.bus_wdata = 16'h0010;
    bus.int_ack = 1'b1;
    tick();
    bus.bus_en = 1'b0; bus.int_ack = 1'b0;
    checkOutput("l4_race_insvc", 32'(bus.in_service), 32'd1);
    checkOutput("l4_race_req", 32'(bus.int_req), 32'd0);
    busRead(2'd0, rd);
    checkOutput("l4_race_pend", 32'(rd), 32'h0);

    // reset during SERVICE
    reset = 1'b1;
    tick();
    checkOutput("rst_insvc", 32'(bus.in_service), 32'd0);
    checkOutput("rst_req", 32'(bus.int_req), 32'd0);
    checkOutput("rst_vec", 32'(bus.int_vec), 32'h0004);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      busRead(2'(a), rd);
      checkOutput($sformatf("rst_reg%0d", a), 32'(rd), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
